// File: rtl/wb_adc_ctrl_pkg.sv
// wb_adc_ctrl_pkg: register map, bit positions, frame length and serial FSM states for the ADC controller.
package wb_adc_ctrl_pkg;
  localparam logic [1:0] ADR_STATUS = 2'd0, ADR_SPI_CMD = 2'd1, ADR_CTRL = 2'd2, ADR_DELAY = 2'd3;
  localparam int ST_BUSY = 0, ST_DONE = 1, ST_OVERRUN = 2, ST_LOCKED = 8;
  localparam int CTRL_RESET = 0, CTRL_SNAP = 1, CTRL_MODE = 24, CTRL_W = 26;
  localparam int FRAME_LEN = 24;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} spi_state_t;
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = sel[i] ? din[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/adc_spi_engine.sv
// adc_spi_engine: autonomous 24-bit write-only serial engine driving chip selects, SCLK and SDATA.
module adc_spi_engine import wb_adc_ctrl_pkg::*; #(
  parameter int N_CHIPS = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FRAME_LEN-1:0] cmd,
  input  logic [N_CHIPS-1:0]   mask,
  output logic                 busy,
  output logic                 done,
  output logic [N_CHIPS-1:0]   csn,
  output logic                 sclk,
  output logic                 sdata
);
  spi_state_t state, state_n;
  logic [7:0] cnt;
  logic [4:0] bit_cnt;
  logic [FRAME_LEN-1:0] sr;
  logic [N_CHIPS-1:0] sel;
  logic phase, tick;
  always_comb begin
    tick = cnt == 8'(CLK_DIV - 1);
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   if (tick) state_n = SHIFT;
      SHIFT:   if (tick && phase && bit_cnt == 5'(FRAME_LEN - 1)) state_n = HOLD;
      HOLD:    if (tick) state_n = DONE;
      DONE:    state_n = start ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      phase <= 1'b0;
      bit_cnt <= '0;
      sr <= '0;
      sel <= '0;
    end else begin
      state <= state_n;
      cnt <= busy && !tick && state_n == state ? cnt + 8'd1 : '0;
      if (start) begin
        sr <= cmd;
        sel <= mask;
        bit_cnt <= '0;
        phase <= 1'b0;
      end else if (state == SHIFT && tick) begin
        phase <= !phase;
        // data advances only on the falling edge so the ADC sees it stable at the rising edge
        if (phase) begin
          sr <= {sr[FRAME_LEN-2:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign csn = busy ? ~sel : '1;
  assign sclk = state == SHIFT && phase;
  assign sdata = sr[FRAME_LEN-1];
endmodule

// File: rtl/wb_adc_spi_controller.sv
// wb_adc_spi_controller: Wishbone register front-end for up to eight ADC chips with a hardware serial engine.
module wb_adc_spi_controller import wb_adc_ctrl_pkg::*; #(
  parameter int N_CHIPS = 8,
  parameter int CLK_DIV = 4,
  parameter int CONTROLLER_REV = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [31:0]            wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic [N_CHIPS-1:0]     adc_csn,
  output logic                   adc_sclk,
  output logic                   adc_sdata,
  output logic                   adc_reset,
  output logic                   adc_snap_req,
  output logic [4*N_CHIPS-1:0]   adc_delay_rst,
  output logic [1:0]             adc_demux_mode,
  input  logic [1:0]             adc_locked
);
  logic req, wr, accept, busy, eng_done, done, overrun;
  logic [1:0] word, lock_meta, lock_sync;
  logic [31:0] cmd, cmd_n, wdat, rdata;
  assign word = wb_adr_i[3:2];
  assign req = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign wr = req && wb_we_i;
  assign accept = wr && word == ADR_SPI_CMD && !busy;
  assign cmd_n = byte_merge(cmd, wb_dat_i, wb_sel_i);
  assign wdat = byte_merge('0, wb_dat_i, wb_sel_i);
  assign wb_err_o = 1'b0;
  always_comb
    rdata = word == ADR_STATUS ? {8'(N_CHIPS), 8'(CONTROLLER_REV), 6'd0, lock_sync, 5'd0, overrun, done, busy}
          : word == ADR_SPI_CMD ? cmd
          : word == ADR_CTRL ? {6'd0, adc_demux_mode, 23'd0, adc_reset} : '0;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      lock_meta <= '0;
      lock_sync <= '0;
      adc_snap_req <= 1'b0;
      adc_delay_rst <= '0;
      adc_reset <= 1'b0;
      adc_demux_mode <= '0;
      cmd <= '0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req && !wb_we_i ? rdata : '0;
      lock_meta <= adc_locked;
      lock_sync <= lock_meta;
      adc_snap_req <= wr && word == ADR_CTRL && wdat[CTRL_SNAP];
      adc_delay_rst <= wr && word == ADR_DELAY ? wdat[4*N_CHIPS-1:0] : '0;
      if (accept) cmd <= cmd_n;
      done <= !accept && (done || eng_done);
      // a command write while busy flags overrun; an accepted one clears it
      overrun <= wr && word == ADR_SPI_CMD ? busy : overrun;
      if (wr && word == ADR_CTRL) begin
        if (wb_sel_i[0]) adc_reset <= wb_dat_i[CTRL_RESET];
        if (wb_sel_i[3] && wb_dat_i[CTRL_W]) adc_demux_mode <= wb_dat_i[CTRL_MODE+:2];
      end
    end
  adc_spi_engine #(.N_CHIPS(N_CHIPS), .CLK_DIV(CLK_DIV)) u_engine (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .start(accept),
    .cmd(cmd_n[31:8]),
    .mask(cmd_n[N_CHIPS-1:0]),
    .busy(busy),
    .done(eng_done),
    .csn(adc_csn),
    .sclk(adc_sclk),
    .sdata(adc_sdata)
  );
endmodule

// File: tb/tb_wb_adc_spi_controller.sv
// tb_wb_adc_spi_controller: scenario tasks with a read-expectation queue and background frame monitors.
module tb_wb_adc_spi_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0] sel = '0;
  logic we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0] dat_o;
  logic ack, err;
  logic [7:0] csn;
  logic sclk, sdata, adc_reset, snap;
  logic [31:0] dly;
  logic [1:0] mode;
  logic [1:0] locked = 2'd0;
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  int lo_cnt = 0, nb = 0, frames = 0, snap_cnt = 0, dly_cnt = 0;
  logic [23:0] bits = '0;
  logic csn_idle_prev = 1'b1;

  always #5 clk = ~clk;

  wb_adc_spi_controller #(.N_CHIPS(8), .CLK_DIV(4), .CONTROLLER_REV(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .adc_csn(csn), .adc_sclk(sclk), .adc_sdata(sdata), .adc_reset(adc_reset),
    .adc_snap_req(snap), .adc_delay_rst(dly), .adc_demux_mode(mode), .adc_locked(locked)
  );

  always @(negedge clk) begin
    if (csn !== 8'hFF) lo_cnt++;
    if (csn !== 8'hFF && csn_idle_prev) frames++;
    csn_idle_prev = csn === 8'hFF;
    if (snap === 1'b1) snap_cnt++;
    if (dly !== 32'd0) dly_cnt++;
  end

  always @(posedge sclk) begin
    bits = {bits[22:0], sdata};
    nb++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wb_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w, output logic [31:0] r);
    bit got = 0;
    adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1; r = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin r = dat_o; got = 1; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin n_checks++; n_fail++; $display("FAIL wb_ack_timeout: adr=%h got no ack want ack", a); end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_cycle(a, d, s, 1'b1, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_cycle(a, 32'd0, 4'hF, 1'b0, r);
  endtask

  task automatic wait_csn_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (csn === 8'hFF) break;
      @(posedge clk); #1;
    end
    if (i == 2000) begin n_checks++; n_fail++; $display("FAIL csn_idle_timeout: csn=%h want ff", csn); end
  endtask

  task automatic clear_mon();
    lo_cnt = 0; nb = 0; frames = 0; bits = '0;
  endtask

  task automatic test_reset();
    logic [31:0] r, e;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL reset_csn: got %h want ff", csn); end
    n_checks++; if ({sclk, sdata, adc_reset, snap, mode, ack, err} !== 8'd0) begin n_fail++; $display("FAIL reset_outs: got %b want 0", {sclk, sdata, adc_reset, snap, mode, ack, err}); end
    n_checks++; if (dly !== 32'd0 || dat_o !== 32'd0) begin n_fail++; $display("FAIL reset_dly_dat: got %h/%h want 0/0", dly, dat_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'h0802_0000);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL status_unlocked: got %h want %h", r, e); end
    locked = 2'd3;
    repeat (3) @(posedge clk); #1;
    exp_q.push_back(32'h0802_0300);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL status_locked: got %h want %h", r, e); end
  endtask

  task automatic test_ack();
    int acks = 0, bad = 0;
    adr = 32'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      else if (dat_o !== 32'd0) bad++;
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (acks !== 2) begin n_fail++; $display("FAIL ack_held_stb: got %0d acks want 2", acks); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL dat_o_idle: got %0d nonzero want 0", bad); end
  endtask

  task automatic test_spi_frame();
    logic [31:0] r, e;
    clear_mon();
    wb_write(32'h4, 32'h2ABE_EF05, 4'hF);
    n_checks++; if (csn !== 8'hFA) begin n_fail++; $display("FAIL frame_csn: got %h want fa", csn); end
    exp_q.push_back(32'h0802_0301);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL status_busy: got %h want %h", r, e); end
    wait_csn_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++; if (lo_cnt !== 200) begin n_fail++; $display("FAIL frame_csn_low: got %0d want 200", lo_cnt); end
    n_checks++; if (nb !== 24) begin n_fail++; $display("FAIL frame_sclk_edges: got %0d want 24", nb); end
    n_checks++; if (bits !== 24'h2ABEEF) begin n_fail++; $display("FAIL frame_data: got %h want 2abeef", bits); end
    exp_q.push_back(32'h0802_0302);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL status_done: got %h want %h", r, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e;
    clear_mon();
    wb_write(32'h4, 32'h1122_3301, 4'hF);
    repeat (10) @(posedge clk); #1;
    wb_write(32'h4, 32'h5566_7702, 4'hF);
    wait_csn_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++; if (frames !== 1) begin n_fail++; $display("FAIL overrun_frames: got %0d want 1", frames); end
    n_checks++; if (lo_cnt !== 200 || nb !== 24) begin n_fail++; $display("FAIL overrun_len: got %0d/%0d want 200/24", lo_cnt, nb); end
    n_checks++; if (bits !== 24'h112233) begin n_fail++; $display("FAIL overrun_data: got %h want 112233", bits); end
    exp_q.push_back(32'h0802_0306);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL status_overrun: got %h want %h", r, e); end
    exp_q.push_back(32'h1122_3301);
    wb_read(32'h4, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL cmd_readback: got %h want %h", r, e); end
  endtask

  task automatic test_boundaries();
    logic [31:0] r, e;
    clear_mon();
    wb_write(32'h4, 32'hA1A2_A303, 4'hF);
    repeat (199) @(posedge clk); #1;
    n_checks++; if (csn !== 8'hFC) begin n_fail++; $display("FAIL last_hold_csn: got %h want fc", csn); end
    wb_write(32'h4, 32'hB1B2_B3FF, 4'hF);
    n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL done_cycle_csn: got %h want ff", csn); end
    wb_write(32'h4, 32'hC1C2_C30C, 4'hF);
    n_checks++; if (csn !== 8'hF3) begin n_fail++; $display("FAIL done_accept_csn: got %h want f3", csn); end
    wait_csn_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++; if (frames !== 2 || lo_cnt !== 400) begin n_fail++; $display("FAIL boundary_frames: got %0d/%0d want 2/400", frames, lo_cnt); end
    n_checks++; if (nb !== 48 || bits !== 24'hC1C2C3) begin n_fail++; $display("FAIL boundary_data: got %0d/%h want 48/c1c2c3", nb, bits); end
    exp_q.push_back(32'h0802_0302);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL boundary_status: got %h want %h", r, e); end
    exp_q.push_back(32'hC1C2_C30C);
    wb_read(32'h4, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL boundary_cmd: got %h want %h", r, e); end
  endtask

  task automatic test_mask_zero();
    logic [31:0] r, e;
    clear_mon();
    wb_write(32'h4, 32'h1234_5600, 4'hF);
    n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL mask0_csn: got %h want ff", csn); end
    exp_q.push_back(32'h0802_0301);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL mask0_busy: got %h want %h", r, e); end
    repeat (205) @(posedge clk); #1;
    exp_q.push_back(32'h0802_0302);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL mask0_done: got %h want %h", r, e); end
    n_checks++; if (frames !== 0 || nb !== 24 || bits !== 24'h123456) begin n_fail++; $display("FAIL mask0_frame: got %0d/%0d/%h want 0/24/123456", frames, nb, bits); end
  endtask

  task automatic test_ctrl();
    logic [31:0] r, e;
    snap_cnt = 0;
    wb_write(32'h8, 32'h0500_0002, 4'hF);
    n_checks++; if (snap !== 1'b1 || mode !== 2'd1) begin n_fail++; $display("FAIL ctrl_snap_mode: got %b/%0d want 1/1", snap, mode); end
    @(posedge clk); #1;
    n_checks++; if (snap !== 1'b0 || snap_cnt !== 1) begin n_fail++; $display("FAIL snap_pulse: got %b/%0d want 0/1", snap, snap_cnt); end
    wb_write(32'h8, 32'h0200_0000, 4'hF);
    n_checks++; if (mode !== 2'd1) begin n_fail++; $display("FAIL mode_guard: got %0d want 1", mode); end
    wb_write(32'h8, 32'h0600_0001, 4'h7);
    n_checks++; if (mode !== 2'd1 || adc_reset !== 1'b1) begin n_fail++; $display("FAIL mode_sel_reset: got %0d/%b want 1/1", mode, adc_reset); end
    exp_q.push_back(32'h0100_0001);
    wb_read(32'h8, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL ctrl_read1: got %h want %h", r, e); end
    wb_write(32'h8, 32'h0600_0000, 4'hF);
    exp_q.push_back(32'h0200_0000);
    wb_read(32'h8, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL ctrl_read2: got %h want %h", r, e); end
  endtask

  task automatic test_delay();
    logic [31:0] r, e;
    dly_cnt = 0;
    wb_write(32'hC, 32'h0000_0011, 4'hF);
    n_checks++; if (dly !== 32'h11) begin n_fail++; $display("FAIL delay_pulse: got %h want 11", dly); end
    @(posedge clk); #1;
    n_checks++; if (dly !== 32'h0 || dly_cnt !== 1) begin n_fail++; $display("FAIL delay_width: got %h/%0d want 0/1", dly, dly_cnt); end
    wb_write(32'hC, 32'h0000_1100, 4'h1);
    @(posedge clk); #1;
    n_checks++; if (dly_cnt !== 1) begin n_fail++; $display("FAIL delay_sel: got %0d want 1", dly_cnt); end
    exp_q.push_back(32'h0);
    wb_read(32'hC, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL delay_read: got %h want %h", r, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, e;
    wb_write(32'h4, 32'h0F0F_0FFF, 4'hF);
    repeat (104) @(posedge clk); #1;
    n_checks++; if (csn !== 8'h00 || sclk !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %h/%b want 00/1", csn, sclk); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (csn !== 8'hFF || sclk !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %h/%b want ff/0", csn, sclk); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    exp_q.push_back(32'h0802_0300);
    wb_read(32'h0, r); e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL mid_status: got %h want %h", r, e); end
    n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL mid_idle: got %h want ff", csn); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_spi_frame();
    test_back_to_back();
    test_boundaries();
    test_mask_zero();
    test_ctrl();
    test_delay();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_adc_spi_controller.md
# wb_adc_spi_controller

Wishbone-slave controller for up to eight ADC chips. It generalises the bit-banged 3-wire ADC controller by adding a hardware serial engine: software writes one 24-bit command and the block generates chip-select, SCLK and SDATA autonomously. It also provides self-clearing strobes for snapshot and delay reset, plus a guarded demux-mode field. It sits on the Wishbone register bus and drives the ADC configuration pins and the capture datapath controls.

## Interface
Parameters:
- N_CHIPS, 8, number of ADC chips, legal range 1..8.
- CLK_DIV, 4, wb_clk_i cycles per SCLK half-period, legal range 2..255.
- CONTROLLER_REV, 2, read-only revision reported in STATUS.

Ports (one clock; reset is asynchronous and active-high):
- wb_clk_i  in  1  bus and block clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i  in  32/32/4/1/1/1  Wishbone slave inputs.
- wb_dat_o, wb_ack_o, wb_err_o  out  32/1/1  Wishbone slave outputs.
- adc_csn  out  N_CHIPS  chip selects, active low.
- adc_sclk  out  1  serial clock, idles low.
- adc_sdata  out  1  serial data, MSB first.
- adc_reset  out  1  level ADC reset.
- adc_snap_req  out  1  one-cycle snapshot pulse.
- adc_delay_rst  out  4*N_CHIPS  one-cycle IDELAY reset pulses.
- adc_demux_mode  out  2  demux mode.
- adc_locked  in  2  line-clock lock status, asynchronous, double-flopped internally.

## Operation
Register decode uses wb_adr_i[3:2]:
- Word 0, STATUS (read-only; writes are acked and ignored):
  - [31:24] N_CHIPS
  - [23:16] CONTROLLER_REV
  - [9:8] synchronised adc_locked
  - [2] overrun, sticky
  - [1] done, sticky
  - [0] busy
- Word 1, SPI_CMD (read returns the last accepted command):
  - Fields: [31:24] register address, [23:8] register data, [7:0] chip mask (bit set = select; bits at and above N_CHIPS are ignored).
  - Write while idle: latch the command, clear done and overrun, start a transaction.
  - Write while busy: command is discarded, overrun is set, and the write is still acked.
- Word 2, CTRL:
  - [0] adc_reset, level.
  - [1] snap, write-1 pulse; reads as 0.
  - [26] W. Bits [25:24] update only when W=1 in the same write with wb_sel_i[3] set.
  - Readback: [25:24] current mode, [0] reset.
- Word 3, DELAY: write-1 bits [4*N_CHIPS-1:0] produce a one-cycle pulse on adc_delay_rst. Reads as 0.
- Byte enables apply to all writable fields.

Serial engine FSM:
- IDLE: csn all 1, sclk 0. On an accepted command: assert csn (mask) and load the 24-bit shift register {addr, data}. Go to SETUP.
- SETUP: sdata = bit 23. Hold CLK_DIV cycles, then go to SHIFT.
- SHIFT: 24 bits. Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high. The ADC samples on the rising edge. sdata changes only on the falling edge.
- HOLD: after the 24th falling edge, sclk 0 for CLK_DIV cycles with csn still asserted.
- DONE: deassert csn, clear busy, set done. Return to IDLE next cycle.

## Timing
- Reset values: csn all 1; sclk, sdata, adc_reset, snap, delay_rst, demux_mode, ack, busy, done and overrun all 0.
- Wishbone:
  - ack is asserted the cycle after stb&cyc and is held for exactly one cycle.
  - stb held high does not produce back-to-back acks; the next transfer needs the ack low first.
  - wb_dat_o is 0 whenever ack is low. wb_err_o is tied to 0.
- Write effects:
  - Register writes take effect on the same edge that asserts ack.
  - The snap and delay_rst pulses are high for the single cycle that coincides with ack.
- Serial transaction timing:
  - busy rises the cycle after the accepting edge.
  - csn asserts together with busy.
  - Total csn-low time is 50*CLK_DIV cycles.
  - busy falls in the DONE cycle. A new command is accepted from the following cycle.
- Boundaries:
  - A command write in the DONE cycle is accepted, because busy is already low.
  - A write in the last HOLD cycle is rejected as overrun.
  - A mask of 0 runs the full timing with no csn asserted, and done is still set.
  - Asserting reset mid-transaction releases csn high and sclk low immediately (asynchronous) and returns to IDLE with no partial completion flag.

## Structure
- Package wb_adc_ctrl_pkg:
  - word offsets (0..3)
  - STATUS/CTRL bit positions
  - frame length 24
  - FSM state enum {IDLE, SETUP, SHIFT, HOLD, DONE}
- Sub-module adc_spi_engine holds the FSM, clock divider, bit counter and shift register. Its interface is start/cmd/mask in and busy/done/csn/sclk/sdata out.
- The top level contains the Wishbone decode, registers, pulse generation and lock synchroniser.

## Test plan
- Reset, then read word 0 → 0x0802_0000 with adc_locked=0, or 0x0802_0300 with adc_locked=3; csn=0xFF.
- With CLK_DIV=4, write 0x2A_BEEF_05 to word 1 → csn=0xFA for 200 cycles, then 24 sclk rising edges carry 0x2ABEEF MSB first, then status reads 0x...0002.
- Write word 1 again 10 cycles into a transaction → the first frame completes unchanged, a single frame only, and status bit 2 = 1.
- Write word 2 with 0x0500_0002 → demux_mode=1 and snap pulses for 1 cycle. Then write 0x0200_0000 → demux_mode stays 1.
- Write word 3 with 0x0000_0011 → delay_rst[0] and delay_rst[4] high for exactly one cycle; word 3 reads as 0.
- Assert wb_rst_i at shift bit 12 → csn=0xFF and sclk=0 without waiting for a clock edge. After release, busy=0 and done=0.
